// File: rtl/bitmap_pkg.sv
// rtl/bitmap_pkg.sv - shared constants and index helpers for the bitmap scan-out controller
package bitmap_pkg;

    // Bit n set means n bits per pixel is a supported depth.
    localparam logic [4:0] BPP_LEGAL_SET = 5'b10110;

    function automatic bit bpp_legal(input int bpp);
        return (bpp >= 0) && (bpp < 5) && BPP_LEGAL_SET[bpp];
    endfunction

    function automatic int ppb_of(input int bpp);
        return 8 / bpp;
    endfunction

    function automatic int sub_w_of(input int bpp);
        return $clog2(8 / bpp);
    endfunction

    function automatic logic [3:0] expand_idx(input int bpp, input logic [3:0] idx);
        case (bpp)
            1:       return {4{idx[0]}};
            2:       return {2{idx[1:0]}};
            default: return idx;
        endcase
    endfunction

endpackage

// File: rtl/bitmap_palette.sv
// rtl/bitmap_palette.sv - 16x4 palette register file, reset to the fixed expansion table
module bitmap_palette
    import bitmap_pkg::*;
#(
    parameter int BPP = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [3:0] widx,
    input  logic [3:0] wdata,
    input  logic [3:0] ridx,
    output logic [3:0] rdata
);

    logic [3:0] mem [16];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++)
                mem[i] <= (i < (1 << BPP)) ? expand_idx(BPP, 4'(i)) : 4'h0;
        end else if (we) begin
            mem[widx] <= wdata;
        end
    end

    // Combinational read: a same-cycle write is seen only from the next clock.
    assign rdata = mem[ridx];

endmodule

// File: rtl/bitmap_fetch_ctrl.sv
// rtl/bitmap_fetch_ctrl.sv - bitmap scan-out fetch controller; BITMAP_PALETTE_EN adds a 16x4 palette
module bitmap_fetch_ctrl
    import bitmap_pkg::*;
#(
    parameter int BPP         = 1,
    parameter int SCALE_SHIFT = 1,
    parameter int X_W         = 10,
    parameter int Y_W         = 9,
    parameter int ADDR_W      = 16,
    parameter int ROW_SHIFT   = 8,
    parameter int MEM_LAT     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              de,
    input  logic [X_W-1:0]    posx,
    input  logic [Y_W-1:0]    posy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_data,
`ifdef BITMAP_PALETTE_EN
    input  logic              pal_we,
    input  logic [3:0]        pal_idx,
    input  logic [3:0]        pal_data,
`endif
    output logic              bus_free,
    output logic [3:0]        pix,
    output logic              de_out
);

    // An unsupported depth degrades to 1 bpp rather than producing garbage widths.
    localparam int EFF_BPP = bpp_legal(BPP) ? BPP : 1;
    localparam int SUB_W = sub_w_of(EFF_BPP);
    localparam logic [3:0] IDX_MASK = 4'((1 << EFF_BPP) - 1);

    logic [X_W-1:0]    col;
    logic [Y_W-1:0]    row;
    logic [Y_W-1:0]    row_q;
    logic [SUB_W-1:0]  sub;
    logic [ADDR_W-1:0] addr_c;
    logic              issue;
    logic              tag_valid;
    logic [ADDR_W-1:0] tag_addr;

    logic [SUB_W-1:0]  sub_pipe [MEM_LAT+1];
    logic [MEM_LAT:0]  de_pipe;
    logic [MEM_LAT-1:0] rd_dly;
    logic [7:0]        byte_q;
    logic [7:0]        cur_byte;
    logic [2:0]        bit_off;
    logic [3:0]        idx;
    logic [3:0]        pix_next;

    always_comb begin
        col    = posx >> SCALE_SHIFT;
        row    = posy >> SCALE_SHIFT;
        sub    = col[SUB_W-1:0];
        addr_c = (ADDR_W'(row) << ROW_SHIFT) + ADDR_W'(col >> SUB_W);
        // A row change forces a fetch even if the wrapped address matches the tag.
        issue  = de && (!tag_valid || (addr_c != tag_addr) || (row != row_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid <= 1'b0;
            tag_addr  <= '0;
            row_q     <= '0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
        end else begin
            row_q  <= row;
            mem_rd <= issue;
            if (issue) begin
                tag_valid <= 1'b1;
                tag_addr  <= addr_c;
                mem_addr  <= addr_c;
            end else if (!de || (row != row_q)) begin
                tag_valid <= 1'b0;
            end
        end
    end

    assign bus_free = !mem_rd;

    // Sub-index and enable travel with the read so selection meets the matching byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= MEM_LAT; i++)
                sub_pipe[i] <= '0;
            de_pipe <= '0;
            rd_dly  <= '0;
            byte_q  <= '0;
        end else begin
            sub_pipe[0] <= sub;
            de_pipe[0]  <= de;
            for (int i = 1; i <= MEM_LAT; i++) begin
                sub_pipe[i] <= sub_pipe[i-1];
                de_pipe[i]  <= de_pipe[i-1];
            end
            rd_dly[0] <= mem_rd;
            for (int i = 1; i < MEM_LAT; i++)
                rd_dly[i] <= rd_dly[i-1];
            if (rd_dly[MEM_LAT-1])
                byte_q <= mem_data;
        end
    end

    always_comb begin
        cur_byte = rd_dly[MEM_LAT-1] ? mem_data : byte_q;
        bit_off  = 3'(int'(sub_pipe[MEM_LAT]) * EFF_BPP);
        idx      = 4'(cur_byte >> bit_off) & IDX_MASK;
    end

`ifdef BITMAP_PALETTE_EN
    bitmap_palette #(
        .BPP   (EFF_BPP)
    ) u_palette (
        .clk   (clk),
        .rst   (rst),
        .we    (pal_we),
        .widx  (pal_idx),
        .wdata (pal_data),
        .ridx  (idx),
        .rdata (pix_next)
    );
`else
    assign pix_next = expand_idx(EFF_BPP, idx);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pix    <= 4'h0;
            de_out <= 1'b0;
        end else begin
            pix    <= de_pipe[MEM_LAT] ? pix_next : 4'h0;
            de_out <= de_pipe[MEM_LAT];
        end
    end

endmodule
